// File: rtl/ss_pkg.sv
// Shared constants, decode table and FSM state type for the seven-segment readback decoder.
package ss_pkg;

    localparam logic [1:0] HOURS2 = 2'd3;
    localparam logic [1:0] HOURS1 = 2'd2;
    localparam logic [1:0] MINS2  = 2'd1;
    localparam logic [1:0] MINS1  = 2'd0;

    // Active-low cathode patterns, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {SYNC, COLLECT, PUBLISH} state_t;

    typedef struct packed {
        logic       err;
        logic [3:0] digit;
    } decode_t;

    function automatic decode_t seg_decode(input logic [6:0] pattern);
        decode_t result;
        result.err = 1'b0;
        case (pattern)
            SEG_0:   result.digit = 4'd0;
            SEG_1:   result.digit = 4'd1;
            SEG_2:   result.digit = 4'd2;
            SEG_3:   result.digit = 4'd3;
            SEG_4:   result.digit = 4'd4;
            SEG_5:   result.digit = 4'd5;
            SEG_6:   result.digit = 4'd6;
            SEG_7:   result.digit = 4'd7;
            SEG_8:   result.digit = 4'd8;
            SEG_9:   result.digit = 4'd9;
            default: begin
                result.digit = 4'hF;
                result.err   = 1'b1;
            end
        endcase
        return result;
    endfunction

endpackage

// File: rtl/ss_glyph_filter.sv
// Samples the display bus, rejects blanking/scan gaps and strobes once per stable glyph dwell.
module ss_glyph_filter
    import ss_pkg::*;
#(
    parameter int STABLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       srst,
    input  logic [7:0] drivers,
    input  logic [7:0] segments,
    output logic       capture,
    output logic [1:0] capture_index,
    output logic [7:0] capture_pattern
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] COUNT_MAX  = CW'(STABLE_CYCLES);
    localparam logic [CW-1:0] COUNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    logic [7:0]    drivers_reg;
    logic [7:0]    segments_reg;
    logic [1:0]    index_reg;
    logic [7:0]    pattern_reg;
    logic [CW-1:0] count_reg;
    logic          capture_reg;
    logic [1:0]    capture_index_reg;
    logic [7:0]    capture_pattern_reg;

    logic [1:0] sample_index;
    logic       active;
    logic       same;

    always_comb begin
        sample_index = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (!drivers_reg[i]) sample_index = 2'(i);
        end
    end

    assign active = $onehot(~drivers_reg[3:0]) && (drivers_reg[7:4] == 4'hF)
                    && (segments_reg[6:0] != SEG_BLANK);
    assign same   = (sample_index == index_reg) && (segments_reg == pattern_reg);

    // Inactive samples leave the dwell untouched so PWM gaps do not restart it
    always_ff @(posedge clk) begin
        if (srst) begin
            drivers_reg         <= 8'h00;
            segments_reg        <= 8'h00;
            index_reg           <= 2'd0;
            pattern_reg         <= 8'h00;
            count_reg           <= '0;
            capture_reg         <= 1'b0;
            capture_index_reg   <= 2'd0;
            capture_pattern_reg <= 8'h00;
        end else begin
            drivers_reg  <= drivers;
            segments_reg <= segments;
            capture_reg  <= 1'b0;
            if (active) begin
                if (same) begin
                    if (count_reg < COUNT_MAX) count_reg <= count_reg + 1'b1;
                    if (count_reg == COUNT_LAST) begin
                        capture_reg         <= 1'b1;
                        capture_index_reg   <= index_reg;
                        capture_pattern_reg <= pattern_reg;
                    end
                end else begin
                    index_reg   <= sample_index;
                    pattern_reg <= segments_reg;
                    count_reg   <= COUNT_ONE;
                end
            end
        end
    end

    assign capture         = capture_reg;
    assign capture_index   = capture_index_reg;
    assign capture_pattern = capture_pattern_reg;

endmodule

// File: rtl/ss_readback.sv
// Assembles captured glyphs into coherent four-digit frames and tracks frame staleness.
module ss_readback
    import ss_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic       CLK100MHZ,
    input  logic       Reset,
    input  logic [7:0] SegmentDrivers,
    input  logic [7:0] SevenSegment,
    output logic [3:0] Hours2,
    output logic [3:0] Hours1,
    output logic [3:0] Mins2,
    output logic [3:0] Mins1,
    output logic [3:0] Dp,
    output logic [3:0] Digit_err,
    output logic       Frame_valid,
    output logic       Stale
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);

    logic       capture;
    logic [1:0] capture_index;
    logic [7:0] capture_pattern;
    decode_t    decoded;
    logic       store;

    state_t          state_reg;
    logic [3:0]      seen_reg;
    logic [3:0][3:0] slot_digit_reg;
    logic [3:0]      slot_dp_reg;
    logic [3:0]      slot_err_reg;
    logic [TW-1:0]   timeout_reg;

    logic [3:0]      hit;
    logic [3:0]      seen_next;
    logic [3:0][3:0] slot_digit_next;
    logic [3:0]      slot_dp_next;
    logic [3:0]      slot_err_next;

    ss_glyph_filter #(
        .STABLE_CYCLES(STABLE_CYCLES)
    ) u_filter (
        .clk            (CLK100MHZ),
        .srst           (Reset),
        .drivers        (SegmentDrivers),
        .segments       (SevenSegment),
        .capture        (capture),
        .capture_index  (capture_index),
        .capture_pattern(capture_pattern)
    );

    assign decoded = seg_decode(capture_pattern[6:0]);
    // While syncing, only an hours2 capture may start a frame
    assign store   = capture && ((state_reg != SYNC) || (capture_index == HOURS2));

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_slot
            assign hit[gi]             = store && (capture_index == 2'(gi));
            assign slot_digit_next[gi] = hit[gi] ? decoded.digit : slot_digit_reg[gi];
            assign slot_dp_next[gi]    = hit[gi] ? ~capture_pattern[7] : slot_dp_reg[gi];
            assign slot_err_next[gi]   = hit[gi] ? decoded.err : slot_err_reg[gi];
        end
    endgenerate

    assign seen_next = seen_reg | hit;

    // Outputs load on the edge into PUBLISH so data and Frame_valid appear together
    always_ff @(posedge CLK100MHZ) begin
        if (Reset) begin
            state_reg      <= SYNC;
            seen_reg       <= 4'h0;
            slot_digit_reg <= '0;
            slot_dp_reg    <= 4'h0;
            slot_err_reg   <= 4'h0;
            timeout_reg    <= '0;
            Hours2         <= 4'h0;
            Hours1         <= 4'h0;
            Mins2          <= 4'h0;
            Mins1          <= 4'h0;
            Dp             <= 4'h0;
            Digit_err      <= 4'h0;
            Frame_valid    <= 1'b0;
            Stale          <= 1'b1;
        end else begin
            slot_digit_reg <= slot_digit_next;
            slot_dp_reg    <= slot_dp_next;
            slot_err_reg   <= slot_err_next;
            Frame_valid    <= 1'b0;
            if (timeout_reg != TIMEOUT_MAX) timeout_reg <= timeout_reg + 1'b1;
            if (timeout_reg == TIMEOUT_MAX - 1'b1) Stale <= 1'b1;
            case (state_reg)
                SYNC: begin
                    if (store) begin
                        seen_reg  <= seen_next;
                        state_reg <= COLLECT;
                    end
                end
                COLLECT: begin
                    seen_reg <= seen_next;
                    if (seen_next == 4'hF) begin
                        Hours2      <= slot_digit_next[HOURS2];
                        Hours1      <= slot_digit_next[HOURS1];
                        Mins2       <= slot_digit_next[MINS2];
                        Mins1       <= slot_digit_next[MINS1];
                        Dp          <= slot_dp_next;
                        Digit_err   <= slot_err_next;
                        Frame_valid <= 1'b1;
                        Stale       <= 1'b0;
                        timeout_reg <= '0;
                        state_reg   <= PUBLISH;
                    end
                end
                PUBLISH: begin
                    seen_reg  <= hit;
                    state_reg <= COLLECT;
                end
                default: state_reg <= SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_ss_readback.sv
// Directed and randomized scan sequences checked against a dwell/frame-level reference model.
module tb_ss_readback;

    localparam int S  = 16;
    localparam int TO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] drv = 8'hFF;
    logic [7:0] seg = 8'hFF;
    logic [3:0] Hours2, Hours1, Mins2, Mins1, Dp, Digit_err;
    logic       Frame_valid, Stale;

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    int last_fv = 0;

    logic [23:0] obs_q[$];
    logic [23:0] exp_q[$];
    logic [23:0] last_frame = 24'h0;

    logic [6:0] glyph [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

    // reference model state
    bit         m_sync = 1'b1;
    logic [3:0] m_seen = 4'h0;
    logic [3:0] m_dig [4];
    logic [3:0] m_dp  = 4'h0;
    logic [3:0] m_err = 4'h0;
    logic [1:0] last_idx = 2'd0;
    logic [7:0] last_pat = 8'h00;
    int         run_len  = 0;

    ss_readback #(
        .STABLE_CYCLES (S),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .CLK100MHZ     (clk),
        .Reset         (rst),
        .SegmentDrivers(drv),
        .SevenSegment  (seg),
        .Hours2        (Hours2),
        .Hours1        (Hours1),
        .Mins2         (Mins2),
        .Mins1         (Mins1),
        .Dp            (Dp),
        .Digit_err     (Digit_err),
        .Frame_valid   (Frame_valid),
        .Stale         (Stale)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [4:0] ref_decode(input logic [6:0] p);
        for (int i = 0; i < 10; i++) begin
            if (p == glyph[i]) return {1'b0, 4'(i)};
        end
        return {1'b1, 4'hF};
    endfunction

    function automatic logic [7:0] g8(input int d, input bit dp_lit);
        return {~dp_lit, glyph[d]};
    endfunction

    function automatic void model_reset();
        m_sync   = 1'b1;
        m_seen   = 4'h0;
        last_idx = 2'd0;
        last_pat = 8'h00;
        run_len  = 0;
    endfunction

    function automatic void model_capture(input logic [1:0] idx, input logic [7:0] pat);
        logic [4:0] dec;
        dec = ref_decode(pat[6:0]);
        if (m_sync && idx != 2'd3) return;
        m_sync      = 1'b0;
        m_dig[idx]  = dec[3:0];
        m_dp[idx]   = ~pat[7];
        m_err[idx]  = dec[4];
        m_seen[idx] = 1'b1;
        if (m_seen == 4'hF) begin
            exp_q.push_back({m_dig[3], m_dig[2], m_dig[1], m_dig[0], m_dp, m_err});
            m_seen = 4'h0;
        end
    endfunction

    // A dwell captures once its run of identical active samples reaches S
    function automatic void model_dwell(input logic [1:0] idx, input logic [7:0] pat, input int n);
        int prev;
        if (idx == last_idx && pat == last_pat) begin
            prev    = run_len;
            run_len = run_len + n;
            if (prev < S && run_len >= S) model_capture(idx, pat);
        end else begin
            last_idx = idx;
            last_pat = pat;
            run_len  = n;
            if (n >= S) model_capture(idx, pat);
        end
    endfunction

    task automatic cyc(input logic [7:0] d, input logic [7:0] s);
        drv = d;
        seg = s;
        @(negedge clk);
        cyc_n++;
        if (Frame_valid) begin
            obs_q.push_back({Hours2, Hours1, Mins2, Mins1, Dp, Digit_err});
            last_fv = cyc_n;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic dwell(input logic [1:0] idx, input logic [7:0] pat, input int n, input bit pwm);
        logic [7:0] d;
        logic [7:0] d2;
        logic [1:0] idx2;
        d    = {4'hF, ~(4'b0001 << idx)};
        idx2 = idx + 2'd1;
        d2   = d;
        d2[idx2] = 1'b0;
        model_dwell(idx, pat, n);
        for (int k = 0; k < n; k++) begin
            cyc(d, pat);
            if (pwm) begin
                case ($urandom_range(0, 3))
                    0:       cyc(d, {pat[7], 7'h7F});
                    1:       cyc(8'hFF, pat);
                    2:       cyc(d2, pat);
                    default: cyc({4'h7, d[3:0]}, pat);
                endcase
            end
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) cyc(8'hFF, 8'hFF);
        rst = 1'b0;
        model_reset();
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_values(input string tag);
        chk($sformatf("%s_digits", tag), {16'h0, Hours2, Hours1, Mins2, Mins1}, 32'h0);
        chk($sformatf("%s_dp", tag), {28'h0, Dp}, 32'h0);
        chk($sformatf("%s_err", tag), {28'h0, Digit_err}, 32'h0);
        chk($sformatf("%s_fv", tag), {31'h0, Frame_valid}, 32'h0);
        chk($sformatf("%s_stale", tag), {31'h0, Stale}, 32'h1);
    endtask

    task automatic compare_frames(input string tag);
        repeat (30) cyc(8'hFF, 8'hFF);
        chk($sformatf("%s_nframes", tag), obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            chk($sformatf("%s_frame%0d", tag, i), {8'h0, obs_q[i]}, {8'h0, exp_q[i]});
        end
        if (exp_q.size() > 0) last_frame = exp_q[exp_q.size() - 1];
        $display("%s: frames observed %0d expected %0d", tag, obs_q.size(), exp_q.size());
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic scan4(input int h2, input int h1, input int m2, input int m1, input bit pwm);
        dwell(2'd3, g8(h2, 1'b0), 64, pwm);
        dwell(2'd2, g8(h1, 1'b0), 64, pwm);
        dwell(2'd1, g8(m2, 1'b0), 64, pwm);
        dwell(2'd0, g8(m1, 1'b0), 64, pwm);
    endtask

    initial begin
        do_reset();
        check_reset_values("reset");

        scan4(1, 2, 3, 4, 1'b0);
        compare_frames("scan_1234");
        chk("scan_hours2", {28'h0, Hours2}, 32'h1);
        chk("scan_mins1", {28'h0, Mins1}, 32'h4);
        chk("scan_stale", {31'h0, Stale}, 32'h0);

        scan4(1, 2, 3, 4, 1'b1);
        compare_frames("scan_pwm");

        do_reset();
        dwell(2'd1, g8(5, 1'b0), 64, 1'b0);
        dwell(2'd0, g8(6, 1'b0), 64, 1'b0);
        compare_frames("sync_no_publish");
        scan4(7, 8, 9, 0, 1'b0);
        compare_frames("sync_first_frame");

        dwell(2'd3, g8(5, 1'b1), 40, 1'b0);
        dwell(2'd2, g8(6, 1'b0), 40, 1'b0);
        dwell(2'd1, g8(7, 1'b1), 40, 1'b0);
        dwell(2'd0, 8'hFE, 40, 1'b0);
        compare_frames("invalid_mins1");
        chk("invalid_err", {28'h0, Digit_err}, 32'h1);
        chk("invalid_mins1_val", {28'h0, Mins1}, 32'hF);

        dwell(2'd3, g8(2, 1'b0), 10, 1'b0);
        dwell(2'd3, g8(3, 1'b0), 10, 1'b0);
        compare_frames("short_dwell");

        for (int r = 0; r < 6; r++) begin
            for (int j = 3; j >= 0; j--) begin
                logic [7:0] pat;
                if ($urandom_range(0, 7) == 0) begin
                    pat = 8'($urandom);
                    if (pat[6:0] == 7'h7F) pat[6:0] = 7'h7E;
                end else begin
                    pat = g8($urandom_range(0, 9), $urandom_range(0, 1) == 1);
                end
                dwell(2'(j), pat, $urandom_range(8, 40), $urandom_range(0, 1) == 1);
            end
        end
        compare_frames("random");

        scan4(2, 3, 5, 9, 1'b0);
        compare_frames("pre_timeout");
        while (cyc_n < last_fv + TO - 5) cyc(8'hFF, 8'hFF);
        chk("stale_before_timeout", {31'h0, Stale}, 32'h0);
        while (cyc_n < last_fv + TO + 5) cyc(8'hFF, 8'hFF);
        chk("stale_after_timeout", {31'h0, Stale}, 32'h1);
        chk("hold_after_timeout", {8'h0, Hours2, Hours1, Mins2, Mins1, Dp, Digit_err},
            {8'h0, last_frame});

        dwell(2'd3, g8(1, 1'b0), 40, 1'b0);
        dwell(2'd2, g8(2, 1'b0), 40, 1'b0);
        do_reset();
        check_reset_values("mid_reset");
        dwell(2'd1, g8(3, 1'b0), 40, 1'b0);
        dwell(2'd0, g8(4, 1'b0), 40, 1'b0);
        scan4(5, 6, 7, 8, 1'b1);
        compare_frames("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ss_readback.md
# ss_readback

Seven-segment scan readback decoder: the receiving end of the multiplexed display bus that the clock's seven-segment driver produces. It watches the active-low segment and digit-driver lines and filters out PWM blanking and scan transitions. It decodes each stable glyph back to BCD and publishes the four displayed digits (hours2, hours1, mins2, mins1) as one coherent frame. It sits alongside the display driver, on the same clock, for self-check and bench readback.

## Interface
- STABLE_CYCLES, 16: consecutive identical active samples required to accept a glyph (≥2).
- TIMEOUT_CYCLES, 1048576: cycles without a published frame before Stale asserts.
- CLK100MHZ  in  1  system clock; all logic on rising edge.
- Reset  in  1  synchronous, active-high reset.
- SegmentDrivers  in  8  active-low digit enables. Bit 3 = hours2, 2 = hours1, 1 = mins2, 0 = mins1. Bits 7:4 unused, expected high.
- SevenSegment  in  8  active-low cathodes, bit order {DP,g,f,e,d,c,b,a}.
- Hours2, Hours1, Mins2, Mins1  out  4 each  last published BCD digits; 4'hF = undecodable glyph.
- Dp  out  4  last published decimal-point state per digit (1 = lit), same bit mapping as SegmentDrivers[3:0].
- Digit_err  out  4  per-digit flag from last frame: glyph not in decode table.
- Frame_valid  out  1  one-cycle pulse when a new frame is published.
- Stale  out  1  high when no frame has been published for TIMEOUT_CYCLES, or none since reset.

## Operation
- Both inputs are registered once (sample stage). All decisions use the registered sample.
- A sample is active when all of the following hold:
  - exactly one of SegmentDrivers[3:0] is low;
  - SegmentDrivers[7:4] = 4'hF;
  - SevenSegment[6:0] ≠ 7'h7F.
  Anything else is inactive: PWM-off, blanking, or a scan gap.
- Stability filter:
  - An active sample equal to the held {index, pattern} increments the counter, saturating at STABLE_CYCLES.
  - A different active sample loads the new {index, pattern} and sets the counter to 1.
  - Inactive samples hold the counter unchanged, so PWM gaps do not break a dwell.
- Capture fires once per dwell, in the cycle the counter goes from STABLE_CYCLES-1 to STABLE_CYCLES. It writes the decoded digit and DP into the slot for that index and sets that slot's seen bit.
- Decode table, SevenSegment[6:0] → digit:
  - 40→0, 79→1, 24→2, 30→3, 19→4;
  - 12→5, 02→6, 78→7, 00→8, 10→9;
  - any other pattern → 4'hF, with the slot error bit set.
- FSM:
  - SYNC: ignore captures until a capture on index 3 (hours2). That capture is stored and the FSM moves to COLLECT.
  - COLLECT: store captures. When the seen mask becomes 4'hF, go to PUBLISH.
  - PUBLISH (1 cycle): copy slots to outputs, pulse Frame_valid, clear Stale and the timeout counter, clear the seen mask, return to COLLECT.
- A capture that lands in the PUBLISH cycle is stored and counts toward the next frame.
- A repeated capture on an already-seen index overwrites that slot. The newest value wins.
- Timeout counter:
  - increments every cycle and saturates;
  - sets Stale when it reaches TIMEOUT_CYCLES;
  - is cleared only by PUBLISH.

## Timing
- Reset values: digit outputs 0, Dp 0, Digit_err 0, Frame_valid 0, Stale 1. FSM goes to SYNC; seen mask, counters and slots are cleared.
- Reset mid-dwell or mid-frame discards all partial state. The next frame must start from SYNC.
- Input to capture: a glyph first presented at cycle t, held with no inactive gaps, captures at t+STABLE_CYCLES (1 sample stage plus STABLE_CYCLES-1 counts).
- Frame_valid and the output update occur together, 1 cycle after the capture that completes the mask.
- Outputs hold between publishes. There is no handshake and no backpressure: a consumer must sample on Frame_valid.

## Structure
- Package ss_pkg holds:
  - segment pattern constants for 0–9 and blank (7'h7F);
  - the decode function (pattern → {err, digit});
  - digit index constants (HOURS2 = 3 … MINS1 = 0);
  - the FSM state enum {SYNC, COLLECT, PUBLISH}.
- One sub-module, ss_glyph_filter, contains the sample register, active qualification, stability counter, and a one-cycle capture strobe with {index, pattern}. The top level holds the FSM, slots and timeout.

## Test plan
- Scan 1,2,3,4 (hours2..mins1), 64 cycles per digit, no gaps, STABLE_CYCLES = 16 → one Frame_valid after the mins1 capture; Hours2=1, Hours1=2, Mins2=3, Mins1=4; Stale=0.
- Same scan with a 50% PWM (segments 7'h7F on alternate cycles) → same digits; each capture is delayed by the gap cycles only.
- Start the scan at mins2 after reset → no publish until after a hours2 capture; the first frame contains the values from that scan.
- Hold mins1 glyph 7'h7E (invalid) → Mins1=4'hF, Digit_err=4'b0001 in the published frame.
- Glyph changes after 10 cycles, STABLE_CYCLES=16 → no capture; no Frame_valid.
- Stop scanning with TIMEOUT_CYCLES=1000 → Stale=1 at 1000 cycles after the last publish. Outputs hold. Assert Reset mid-frame → all outputs return to reset values and the FSM returns to SYNC.
